// File: rtl/ram_sp_clr_pkg.sv
// Shared types and constants for the single-port RAM with hardware clear.
package ram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

endpackage

// File: rtl/ram_sp_clr_if.sv
// Access bus of ram_sp_clr: requester (master) drives the request, RAM (slave) answers.
interface ram_sp_clr_if #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 3
);

  logic              en;
  logic              rw;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] wmask;
  logic              clr;
  logic              busy;
  logic [DATA_W-1:0] data_out;
  logic              rd_valid;

  modport master (
    output en, rw, addr, data_in, wmask, clr,
    input  busy, data_out, rd_valid
  );

  modport slave (
    input  en, rw, addr, data_in, wmask, clr,
    output busy, data_out, rd_valid
  );

endinterface

// File: rtl/ram_sp_clr_ctrl.sv
// Clear sequencer: CLEAR/IDLE FSM and the address counter that sweeps the array with zeros.
module ram_clr_ctrl
  import ram_pkg::*;
#(
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clr_req,
  output logic              o_busy,
  output logic              o_clr_we,
  output logic [ADDR_W-1:0] o_clr_addr
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_cnt;
  logic [ADDR_W-1:0] w_cnt_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= CLEAR;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // The counter wraps to zero on the last clear write, so it is ready for the next sweep.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      CLEAR: begin
        w_cnt_nxt = r_cnt + 1'b1;
        if (&r_cnt) w_state_nxt = IDLE;
      end
      IDLE: begin
        w_cnt_nxt = '0;
        if (i_clr_req) w_state_nxt = CLEAR;
      end
    endcase
  end

  always_comb begin
    o_busy     = (r_state == CLEAR);
    o_clr_we   = (r_state == CLEAR);
    o_clr_addr = r_cnt;
  end

endmodule

// File: rtl/ram_sp_clr.sv
// Single-port RAM with bit-masked writes, optional output register and a hardware clear sweep.
module ram_sp_clr
  import ram_pkg::*;
#(
  parameter int DATA_W  = 4,
  parameter int ADDR_W  = 3,
  parameter int OUT_REG = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  ram_sp_clr_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_busy;
  logic              w_clr_we;
  logic [ADDR_W-1:0] w_clr_addr;
  logic              w_wr_acc;
  logic              w_rd_acc;

  logic              r_rd_v1;
  logic [DATA_W-1:0] r_rd_q1;

  ram_clr_ctrl #(
    .ADDR_W(ADDR_W)
  ) u_ctrl (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clr_req (bus.clr),
    .o_busy    (w_busy),
    .o_clr_we  (w_clr_we),
    .o_clr_addr(w_clr_addr)
  );

  // A clear request in the same cycle as an access wins; the access is dropped.
  always_comb begin
    w_wr_acc = !w_busy && bus.en && (bus.rw == RW_WRITE) && !bus.clr;
    w_rd_acc = !w_busy && bus.en && (bus.rw == RW_READ)  && !bus.clr;
  end

  always_ff @(posedge clk) begin
    if (w_clr_we) begin
      r_mem[w_clr_addr] <= '0;
    end else if (w_wr_acc) begin
      r_mem[bus.addr] <= (r_mem[bus.addr] & ~bus.wmask) | (bus.data_in & bus.wmask);
    end
  end

  // Read stage is not gated by busy so a read accepted just before a clear still completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_v1 <= 1'b0;
      r_rd_q1 <= '0;
    end else begin
      r_rd_v1 <= w_rd_acc;
      if (w_rd_acc) r_rd_q1 <= r_mem[bus.addr];
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic              r_rd_v2;
      logic [DATA_W-1:0] r_rd_q2;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_rd_v2 <= 1'b0;
          r_rd_q2 <= '0;
        end else begin
          r_rd_v2 <= r_rd_v1;
          if (r_rd_v1) r_rd_q2 <= r_rd_q1;
        end
      end

      always_comb begin
        bus.data_out = r_rd_q2;
        bus.rd_valid = r_rd_v2;
      end
    end else begin : g_no_out_reg
      always_comb begin
        bus.data_out = r_rd_q1;
        bus.rd_valid = r_rd_v1;
      end
    end
  endgenerate

  always_comb bus.busy = w_busy;

endmodule

// File: tb/tb_ram_sp_clr.sv
// Directed bench: one DUT with 1-cycle read latency and one with the output register, same stimulus.
module tb_ram_sp_clr;

  logic clk;
  logic rst_n;

  int n_total;
  int n_bad;

  logic [3:0] exp_arr [8];

  ram_sp_clr_if #(.DATA_W(4), .ADDR_W(3)) u_if0 ();
  ram_sp_clr_if #(.DATA_W(4), .ADDR_W(3)) u_if1 ();

  assign u_if1.en      = u_if0.en;
  assign u_if1.rw      = u_if0.rw;
  assign u_if1.addr    = u_if0.addr;
  assign u_if1.data_in = u_if0.data_in;
  assign u_if1.wmask   = u_if0.wmask;
  assign u_if1.clr     = u_if0.clr;

  ram_sp_clr #(.DATA_W(4), .ADDR_W(3), .OUT_REG(0)) u_dut0 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (u_if0)
  );

  ram_sp_clr #(.DATA_W(4), .ADDR_W(3), .OUT_REG(1)) u_dut1 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (u_if1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [3:0] d, input logic [3:0] m);
    u_if0.en      = 1'b1;
    u_if0.rw      = 1'b0;
    u_if0.addr    = a;
    u_if0.data_in = d;
    u_if0.wmask   = m;
    tick();
    u_if0.en      = 1'b0;
  endtask

  // Consecutive reads base..base+n-1; checks both latencies against exp_arr[0..n-1].
  task automatic rd_seq(input string tag, input int base, input int n);
    for (int i = 0; i < n + 2; i++) begin
      if (i < n) begin
        u_if0.en   = 1'b1;
        u_if0.rw   = 1'b1;
        u_if0.addr = 3'(base + i);
      end else begin
        u_if0.en   = 1'b0;
      end
      tick();
      chk($sformatf("%s_rv0_%0d", tag, i), 32'(u_if0.rd_valid), 32'(i < n));
      if (i < n) chk($sformatf("%s_d0_%0d", tag, i), 32'(u_if0.data_out), 32'(exp_arr[i]));
      chk($sformatf("%s_rv1_%0d", tag, i), 32'(u_if1.rd_valid), 32'(i >= 1 && i <= n));
      if (i >= 1 && i <= n) chk($sformatf("%s_d1_%0d", tag, i), 32'(u_if1.data_out), 32'(exp_arr[i-1]));
    end
  endtask

  task automatic wait_clear(input string tag, input int expected);
    int cyc;
    cyc = 0;
    while (u_if0.busy && cyc < 20) begin
      tick();
      cyc++;
    end
    chk({tag, "_cycles"}, 32'(cyc), 32'(expected));
    chk({tag, "_busy1"}, 32'(u_if1.busy), 32'd0);
  endtask

  initial begin
    int cyc;
    n_total = 0;
    n_bad   = 0;
    rst_n         = 1'b0;
    u_if0.en      = 1'b0;
    u_if0.rw      = 1'b0;
    u_if0.addr    = '0;
    u_if0.data_in = '0;
    u_if0.wmask   = '0;
    u_if0.clr     = 1'b0;

    // Reset state
    #2;
    chk("rst_busy0", 32'(u_if0.busy), 32'd1);
    chk("rst_rv0",   32'(u_if0.rd_valid), 32'd0);
    chk("rst_d0",    32'(u_if0.data_out), 32'd0);
    chk("rst_busy1", 32'(u_if1.busy), 32'd1);
    chk("rst_rv1",   32'(u_if1.rd_valid), 32'd0);
    chk("rst_d1",    32'(u_if1.data_out), 32'd0);
    tick();
    tick();
    chk("rst_hold_busy", 32'(u_if0.busy), 32'd1);
    rst_n = 1'b1;
    wait_clear("init_clear", 8);

    // All addresses zero after the initial sweep
    for (int i = 0; i < 8; i++) exp_arr[i] = 4'h0;
    rd_seq("init_zero", 0, 8);

    // Masked write then immediate read: (A & ~3) | (5 & 3) = 9
    wr(3'd5, 4'hA, 4'hF);
    wr(3'd5, 4'h5, 4'h3);
    exp_arr[0] = 4'h9;
    rd_seq("mask", 5, 1);

    // Fill 1..8, a zero-mask write must not disturb addr 0, then back-to-back reads
    for (int a = 0; a < 8; a++) begin
      wr(3'(a), 4'(a + 1), 4'hF);
      exp_arr[a] = 4'(a + 1);
    end
    wr(3'd0, 4'hF, 4'h0);
    rd_seq("b2b", 0, 8);

    // Fill F, read one to load data_out, then clear with accesses attempted while busy
    for (int a = 0; a < 8; a++) wr(3'(a), 4'hF, 4'hF);
    exp_arr[0] = 4'hF;
    rd_seq("preclr", 3, 1);
    u_if0.clr = 1'b1;
    tick();
    u_if0.clr = 1'b0;
    chk("clr_busy", 32'(u_if0.busy), 32'd1);
    cyc = 0;
    while (u_if0.busy && cyc < 20) begin
      u_if0.en      = 1'b1;
      u_if0.rw      = cyc[0];
      u_if0.addr    = cyc[2:0];
      u_if0.data_in = 4'h5;
      u_if0.wmask   = 4'hF;
      u_if0.clr     = cyc[1];
      tick();
      cyc++;
      chk($sformatf("busy_rv0_%0d", cyc), 32'(u_if0.rd_valid), 32'd0);
      chk($sformatf("busy_rv1_%0d", cyc), 32'(u_if1.rd_valid), 32'd0);
    end
    u_if0.en  = 1'b0;
    u_if0.clr = 1'b0;
    chk("clr_cycles", 32'(cyc), 32'd8);
    chk("clr_hold_d0", 32'(u_if0.data_out), 32'hF);
    chk("clr_hold_d1", 32'(u_if1.data_out), 32'hF);
    for (int i = 0; i < 8; i++) exp_arr[i] = 4'h0;
    rd_seq("post_clr", 0, 8);

    // Read accepted the cycle before clr still completes on the registered output
    wr(3'd1, 4'hC, 4'hF);
    u_if0.en   = 1'b1;
    u_if0.rw   = 1'b1;
    u_if0.addr = 3'd1;
    tick();
    chk("rdclr_rv0", 32'(u_if0.rd_valid), 32'd1);
    chk("rdclr_d0",  32'(u_if0.data_out), 32'hC);
    chk("rdclr_rv1a", 32'(u_if1.rd_valid), 32'd0);
    u_if0.en  = 1'b0;
    u_if0.clr = 1'b1;
    tick();
    u_if0.clr = 1'b0;
    chk("rdclr_busy", 32'(u_if0.busy), 32'd1);
    chk("rdclr_rv0b", 32'(u_if0.rd_valid), 32'd0);
    chk("rdclr_rv1",  32'(u_if1.rd_valid), 32'd1);
    chk("rdclr_d1",   32'(u_if1.data_out), 32'hC);
    wait_clear("rdclr", 8);

    // Same-cycle clr and write: write dropped
    u_if0.clr     = 1'b1;
    u_if0.en      = 1'b1;
    u_if0.rw      = 1'b0;
    u_if0.addr    = 3'd2;
    u_if0.data_in = 4'h7;
    u_if0.wmask   = 4'hF;
    tick();
    u_if0.clr = 1'b0;
    u_if0.en  = 1'b0;
    chk("clrwr_busy", 32'(u_if0.busy), 32'd1);
    wait_clear("clrwr", 8);
    exp_arr[0] = 4'h0;
    rd_seq("clrwr", 2, 1);

    // Same-cycle clr and read: no read completes
    wr(3'd6, 4'h6, 4'hF);
    u_if0.clr  = 1'b1;
    u_if0.en   = 1'b1;
    u_if0.rw   = 1'b1;
    u_if0.addr = 3'd6;
    tick();
    u_if0.clr = 1'b0;
    u_if0.en  = 1'b0;
    chk("clrrd_rv0", 32'(u_if0.rd_valid), 32'd0);
    tick();
    chk("clrrd_rv1", 32'(u_if1.rd_valid), 32'd0);
    wait_clear("clrrd", 7);

    // Reset during an in-flight read discards it
    wr(3'd4, 4'hB, 4'hF);
    u_if0.en   = 1'b1;
    u_if0.rw   = 1'b1;
    u_if0.addr = 3'd4;
    tick();
    u_if0.en = 1'b0;
    chk("rstrd_rv0", 32'(u_if0.rd_valid), 32'd1);
    chk("rstrd_d0",  32'(u_if0.data_out), 32'hB);
    rst_n = 1'b0;
    #1;
    chk("rstrd_d0z",  32'(u_if0.data_out), 32'd0);
    chk("rstrd_rv1z", 32'(u_if1.rd_valid), 32'd0);
    chk("rstrd_busy", 32'(u_if0.busy), 32'd1);
    tick();
    rst_n = 1'b1;
    wait_clear("rstrd", 8);

    // Reset during clear cycle 3 restarts the full sweep
    wr(3'd4, 4'hB, 4'hF);
    exp_arr[0] = 4'hB;
    rd_seq("pre_rst", 4, 1);
    u_if0.clr = 1'b1;
    tick();
    u_if0.clr = 1'b0;
    tick();
    tick();
    chk("midclr_busy", 32'(u_if0.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midclr_d0",    32'(u_if0.data_out), 32'd0);
    chk("midclr_d1",    32'(u_if1.data_out), 32'd0);
    chk("midclr_rv0",   32'(u_if0.rd_valid), 32'd0);
    chk("midclr_busy1", 32'(u_if1.busy), 32'd1);
    tick();
    rst_n = 1'b1;
    wait_clear("midclr", 8);
    exp_arr[0] = 4'h0;
    rd_seq("post_rst", 4, 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
